// File: rtl/waveform_gen_pkg.sv
// waveform_gen_pkg: shared types and constants for the waveform generator
// and its downstream measurement stage (wave_meter).
//   LUT_WIDTH     : generator sample width (signed)
//   PER_WIDTH     : meter period counter width
//   meter_state_t : wave_meter direction tracker state
package waveform_gen_pkg;

  localparam int LUT_WIDTH = 12;
  localparam int PER_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE,
    RISING,
    FALLING
  } meter_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: free-running up counter that sticks at all-ones.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (wins over increment)
//   load_val  : value loaded on load
//   count     : current count
//   sat       : count is all-ones
module sat_counter #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  assign sat = &count;

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= load_val;
    else if (!sat) count <= count + 1'b1;
  end

endmodule

// File: rtl/wave_meter.sv
// wave_meter: measures period (peak to peak, in clocks) and the max/min
// sample over that period of a signed sample stream.
//   clk, rst        : clock, synchronous active-high reset
//   sample_i        : signed sample, taken when sample_valid_i
//   sample_valid_i  : sample qualifier
//   clear_i         : synchronous restart, same effect as rst
//   period_o        : cycles between the last two peaks
//   max_o / min_o   : sample extremes over the last measured period
//   meas_valid_o    : one-cycle pulse when period_o/max_o/min_o update
//   overflow_o      : sticky, the period counter saturated while armed
module wave_meter
  import waveform_gen_pkg::*;
#(
  parameter int DATA_WIDTH = waveform_gen_pkg::LUT_WIDTH,
  parameter int PER_WIDTH  = waveform_gen_pkg::PER_WIDTH,
  parameter int HYST       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_i,
  input  logic                         sample_valid_i,
  input  logic                         clear_i,
  output logic        [PER_WIDTH-1:0]  period_o,
  output logic signed [DATA_WIDTH-1:0] max_o,
  output logic signed [DATA_WIDTH-1:0] min_o,
  output logic                         meas_valid_o,
  output logic                         overflow_o
);

  // Differences of two full-scale samples fit in DATA_WIDTH+1 bits; one more
  // bit keeps the hysteresis constant itself representable as a positive value.
  localparam int CW = DATA_WIDTH + 2;
  localparam logic signed [CW-1:0] HYST_X = CW'(HYST);

  meter_state_t                 state;
  logic signed [DATA_WIDTH-1:0] ext;
  logic signed [DATA_WIDTH-1:0] rmax, rmin;
  logic                         have_ext;
  logic                         have_peak;

  logic signed [CW-1:0]         s_x, ext_x, up, dn;
  logic                         clr, peak;
  logic [PER_WIDTH-1:0]         cnt;
  logic                         cnt_sat;

  assign clr   = rst | clear_i;
  assign s_x   = {{2{sample_i[DATA_WIDTH-1]}}, sample_i};
  assign ext_x = {{2{ext[DATA_WIDTH-1]}}, ext};
  assign up    = s_x - ext_x;
  assign dn    = ext_x - s_x;

  // Peak: first valid sample more than HYST below the tracked maximum.
  assign peak = sample_valid_i && (state == RISING) && (dn > HYST_X);

  // Cleared together with everything else, so a clear coincident with a
  // peak leaves cnt at 0 rather than loading 1.
  sat_counter #(.WIDTH(PER_WIDTH)) u_cnt (
    .clk      (clk),
    .rst      (clr),
    .load     (peak),
    .load_val (PER_WIDTH'(1)),
    .count    (cnt),
    .sat      (cnt_sat)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      ext          <= '0;
      rmax         <= '0;
      rmin         <= '0;
      have_ext     <= 1'b0;
      have_peak    <= 1'b0;
      period_o     <= '0;
      max_o        <= '0;
      min_o        <= '0;
      meas_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      meas_valid_o <= 1'b0;
      if (cnt_sat && have_peak) overflow_o <= 1'b1;

      if (sample_valid_i) begin
        if (sample_i > rmax) rmax <= sample_i;
        if (sample_i < rmin) rmin <= sample_i;

        case (state)
          IDLE: begin
            if (!have_ext) begin
              ext      <= sample_i;
              have_ext <= 1'b1;
            end else if (up > HYST_X) begin
              state <= RISING;
              ext   <= sample_i;
            end else if (dn > HYST_X) begin
              state <= FALLING;
              ext   <= sample_i;
            end
          end

          RISING: begin
            if (peak) begin
              state     <= FALLING;
              ext       <= sample_i;
              have_peak <= 1'b1;
              // Restart the extremes from the detecting sample; it overrides
              // the running update above.
              rmax      <= sample_i;
              rmin      <= sample_i;
              if (have_peak) begin
                period_o     <= cnt;
                max_o        <= rmax;
                min_o        <= rmin;
                meas_valid_o <= 1'b1;
              end
            end else if (sample_i > ext) begin
              ext <= sample_i;
            end
          end

          FALLING: begin
            if (up > HYST_X) begin
              state <= RISING;
              ext   <= sample_i;
            end else if (sample_i < ext) begin
              ext <= sample_i;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
module tb_wave_meter;

  localparam int DW = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic signed [DW-1:0] sample = '0;
  logic                 valid = 1'b0;
  logic                 clear = 1'b0;

  // main meter: HYST 0, 24-bit period
  logic [23:0]          per;
  logic signed [DW-1:0] mx, mn;
  logic                 mv, ovf;
  // HYST 2
  logic [23:0]          h_per;
  logic signed [DW-1:0] h_mx, h_mn;
  logic                 h_mv, h_ovf;
  // 8-bit period counter
  logic [7:0]           o_per;
  logic signed [DW-1:0] o_mx, o_mn;
  logic                 o_mv, o_ovf;

  wave_meter #(.DATA_WIDTH(DW), .PER_WIDTH(24), .HYST(0)) dut (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_valid_i(valid), .clear_i(clear),
    .period_o(per), .max_o(mx), .min_o(mn), .meas_valid_o(mv), .overflow_o(ovf));

  wave_meter #(.DATA_WIDTH(DW), .PER_WIDTH(24), .HYST(2)) dut_h (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_valid_i(valid), .clear_i(clear),
    .period_o(h_per), .max_o(h_mx), .min_o(h_mn), .meas_valid_o(h_mv), .overflow_o(h_ovf));

  wave_meter #(.DATA_WIDTH(DW), .PER_WIDTH(8), .HYST(0)) dut_o (
    .clk(clk), .rst(rst), .sample_i(sample), .sample_valid_i(valid), .clear_i(clear),
    .period_o(o_per), .max_o(o_mx), .min_o(o_mn), .meas_valid_o(o_mv), .overflow_o(o_ovf));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // apply one sample, clock it in, then look at outputs 1ns after the edge
  task automatic step(input int s, input bit v, input bit c);
    sample = DW'(s);
    valid  = v;
    clear  = c;
    @(posedge clk);
    #1;
    clear  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  // kind: 0 triangle -100..100 step 25, 1 ramp up 0..31, 2 ramp down 31..0,
  //       3 rectangle +-50 x20, 4 ramp up with every other cycle invalid
  function automatic int wave(input int kind, input int i);
    int p;
    case (kind)
      0: begin
        p = i % 16;
        return (p <= 8) ? (-100 + 25 * p) : (100 - 25 * (p - 8));
      end
      1: return i % 32;
      2: return 31 - (i % 32);
      3: return ((i % 40) < 20) ? 50 : -50;
      4: return (i % 2 == 0) ? ((i / 2) % 32) : -2000;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    string name;
    int    kind;
    int    cycles;
    int    exp_pulses;
    int    exp_per;
    int    exp_max;
    int    exp_min;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int   pulses, h_pulses, first_at, ovf_at;
    int   first_per, first_max, first_min;
    int   hs[10];

    vecs[0] = '{"tri",      0,  80, 4, 16, 100, -100};
    vecs[1] = '{"saw_up",   1, 130, 3, 32,  31,    0};
    vecs[2] = '{"saw_dn",   2, 130, 3, 32,  31,    0};
    vecs[3] = '{"rect",     3, 150, 2, 40,  50,  -50};
    vecs[4] = '{"saw_hold", 4, 200, 2, 64,  31,    0};

    // reset state
    do_reset();
    chk("rst_per", int'(per), 0);
    chk("rst_max", int'(mx), 0);
    chk("rst_min", int'(mn), 0);
    chk("rst_mv",  int'(mv), 0);
    chk("rst_ovf", int'(ovf), 0);

    // table-driven periodic waveforms
    foreach (vecs[v]) begin
      do_reset();
      pulses = 0;
      for (int i = 0; i < vecs[v].cycles; i++) begin
        step(wave(vecs[v].kind, i), (vecs[v].kind != 4) || (i % 2 == 0), 1'b0);
        if (mv) begin
          pulses++;
          chk({vecs[v].name, "_per"}, int'(per), vecs[v].exp_per);
          chk({vecs[v].name, "_max"}, int'(mx),  vecs[v].exp_max);
          chk({vecs[v].name, "_min"}, int'(mn),  vecs[v].exp_min);
        end
      end
      chk({vecs[v].name, "_pulses"}, pulses, vecs[v].exp_pulses);
    end

    // hysteresis: 10->9 dip is a peak only without hysteresis
    hs = '{0, 10, 9, 12, 20, 17, 10, 14, 20, 17};
    do_reset();
    pulses = 0; h_pulses = 0;
    first_per = -1; first_max = 0; first_min = 0;
    for (int i = 0; i < 10; i++) begin
      step(hs[i], 1'b1, 1'b0);
      if (mv) begin
        if (pulses == 0) begin
          first_per = int'(per); first_max = int'(mx); first_min = int'(mn);
        end
        pulses++;
      end
      if (h_mv) begin
        h_pulses++;
        chk("hyst2_per", int'(h_per), 4);
        chk("hyst2_max", int'(h_mx), 20);
        chk("hyst2_min", int'(h_mn), 10);
      end
    end
    chk("hyst0_pulses", pulses, 2);
    chk("hyst0_per",    first_per, 3);
    chk("hyst0_max",    first_max, 20);
    chk("hyst0_min",    first_min, 9);
    chk("hyst2_pulses", h_pulses, 1);

    // overflow on the 8-bit counter
    do_reset();
    step(0, 1'b1, 1'b0);
    step(10, 1'b1, 1'b0);
    step(5, 1'b1, 1'b0);            // arming peak, cnt <= 1
    ovf_at = -1; pulses = 0;
    for (int k = 1; k <= 300; k++) begin
      step(5, 1'b1, 1'b0);
      if (o_ovf && ovf_at < 0) ovf_at = k;
      if (o_mv) pulses++;
    end
    chk("ovf_rise_cycle", ovf_at, 255);
    chk("ovf_no_pulse",   pulses, 0);
    step(20, 1'b1, 1'b0);
    step(10, 1'b1, 1'b0);           // next peak
    chk("ovf_mv",      int'(o_mv), 1);
    chk("ovf_per",     int'(o_per), 255);
    chk("ovf_max",     int'(o_mx), 20);
    chk("ovf_min",     int'(o_mn), 5);
    chk("ovf_sticky",  int'(o_ovf), 1);
    step(10, 1'b1, 1'b0);
    chk("ovf_mv_once", int'(o_mv), 0);
    chk("ovf_hold",    int'(o_ovf), 1);
    step(10, 1'b1, 1'b1);
    chk("ovf_clear",     int'(o_ovf), 0);
    chk("ovf_clear_per", int'(o_per), 0);

    // reset mid-period discards everything; two new peaks needed
    do_reset();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(wave(0, i), 1'b1, 1'b0);
      if (mv) pulses++;
    end
    chk("mid_pre_pulses", pulses, 1);
    rst = 1'b1;
    step(wave(0, 30), 1'b1, 1'b0);
    rst = 1'b0;
    chk("mid_rst_per", int'(per), 0);
    chk("mid_rst_max", int'(mx), 0);
    chk("mid_rst_min", int'(mn), 0);
    chk("mid_rst_mv",  int'(mv), 0);
    first_at = -1;
    for (int i = 31; i <= 60; i++) begin
      step(wave(0, i), 1'b1, 1'b0);
      if (mv && first_at < 0) begin
        first_at = i;
        chk("mid_post_per", int'(per), 16);
      end
    end
    chk("mid_first_pulse", first_at, 57);

    // clear on the same cycle as a reporting peak: no pulse
    do_reset();
    for (int i = 0; i < 25; i++) step(wave(0, i), 1'b1, 1'b0);
    step(wave(0, 25), 1'b1, 1'b1);
    chk("clr_peak_mv",  int'(mv), 0);
    chk("clr_peak_per", int'(per), 0);
    first_at = -1;
    for (int i = 26; i <= 60; i++) begin
      step(wave(0, i), 1'b1, 1'b0);
      if (mv && first_at < 0) first_at = i;
    end
    chk("clr_first_pulse", first_at, 57);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
